// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: multiply request, MTHI/MTLO writes and the HI/LO/status read side.
interface hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] product;
  logic               mthi;
  logic               mtlo;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               stall;
  logic               done;

  modport master (
    output start, signed_op, op_a, op_b, product, mthi, mtlo, wdata,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, signed_op, op_a, op_b, product, mthi, mtlo, wdata,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO unit: signed correction of the unsigned multiplier product, HI/LO commit,
// MTHI/MTLO writes and the pipeline stall while a multiply is in flight.
module hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hilo_unit_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIX   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] corr_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_c;
  logic             fix_c;
  logic             commit_c;
  logic             hi_we_c;
  logic             lo_we_c;
  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] corr_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_FIX;
      S_FIX:   state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control decode; a start in IDLE takes priority over MTHI/MTLO
  always_comb begin
    accept_c = 1'b0;
    fix_c    = 1'b0;
    commit_c = 1'b0;
    hi_we_c  = 1'b0;
    lo_we_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept_c = bus.start;
        hi_we_c  = !bus.start && bus.mthi;
        lo_we_c  = !bus.start && bus.mtlo;
      end
      S_FIX:   fix_c    = 1'b1;
      S_WRITE: commit_c = 1'b1;
      default: ;
    endcase
  end

  // Two's-complement correction; only its low WIDTH bits matter for HI mod 2^WIDTH
  always_comb begin
    sa_c   = sgn_q && a_q[WIDTH-1];
    sb_c   = sgn_q && b_q[WIDTH-1];
    corr_c = (sa_c ? b_q : '0) + (sb_c ? a_q : '0);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      corr_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (accept_c) begin
        prod_q <= bus.product;
        a_q    <= bus.op_a;
        b_q    <= bus.op_b;
        sgn_q  <= bus.signed_op;
      end
      if (fix_c) corr_q <= corr_c;
      if (commit_c) begin
        hi_q <= prod_q[PW-1:WIDTH] - corr_q;
        lo_q <= prod_q[WIDTH-1:0];
      end else begin
        if (hi_we_c) hi_q <= bus.wdata;
        if (lo_we_c) lo_q <= bus.wdata;
      end
      busy_q <= (state_d != S_IDLE);
      done_q <= commit_c;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.stall = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: vector table of multiplies plus MT/abort sequences.
module tb_hilo_unit;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  hilo_unit_if #(.WIDTH(W)) bus ();

  hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          so;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  exp_hi;
    logic [W-1:0]  exp_lo;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.product   = '0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.wdata     = '0;
  endtask

  // One multiply, with optional disturbances: MT write during FIX, second start
  // during FIX, MTHI in the same cycle as the accepted start.
  task automatic do_mult(input string tag, input logic so, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input bit mt_busy,
                         input bit start_fix, input bit mthi_start);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = so;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.product   = 64'(a) * 64'(b);
    bus.mthi      = mthi_start;
    bus.wdata     = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    check({tag, " busy E0"},  64'(bus.busy),  64'd1);
    check({tag, " stall E0"}, 64'(bus.stall), 64'd1);
    check({tag, " done E0"},  64'(bus.done),  64'd0);
    if (start_fix) begin
      bus.start     = 1'b1;
      bus.signed_op = 1'b0;
      bus.op_a      = 32'd5;
      bus.op_b      = 32'd5;
      bus.product   = 64'd25;
    end
    if (mt_busy) begin
      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'hFFFFFFFF;
    end
    @(negedge clk);
    idle_inputs();
    check({tag, " busy E1"}, 64'(bus.busy), 64'd1);
    check({tag, " done E1"}, 64'(bus.done), 64'd0);
    @(negedge clk);
    check({tag, " busy E2"},  64'(bus.busy),  64'd0);
    check({tag, " stall E2"}, 64'(bus.stall), 64'd0);
    check({tag, " done E2"},  64'(bus.done),  64'd1);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, " done E3"}, 64'(bus.done), 64'd0);
    check({tag, " hi hold"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo hold"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [W-1:0] d);
    @(negedge clk);
    bus.mthi  = wh;
    bus.mtlo  = wl;
    bus.wdata = d;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int dones;
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[2] = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[3] = '{1'b0, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[4] = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[5] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6] = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[7] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset hi",    64'(bus.hi),    64'd0);
    check("reset lo",    64'(bus.lo),    64'd0);
    check("reset busy",  64'(bus.busy),  64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset done",  64'(bus.done),  64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_mult($sformatf("vec%0d", i), vecs[i].so, vecs[i].a, vecs[i].b,
              vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, 1'b0, 1'b0);

    // MTHI then MTLO, then both together
    mt_write(1'b1, 1'b0, 32'h12345678);
    check("mthi hi", 64'(bus.hi), 64'h12345678);
    mt_write(1'b0, 1'b1, 32'h9ABCDEF0);
    check("mtlo hi", 64'(bus.hi), 64'h12345678);
    check("mtlo lo", 64'(bus.lo), 64'h9ABCDEF0);
    mt_write(1'b1, 1'b1, 32'h55AA55AA);
    check("mtboth hi", 64'(bus.hi), 64'h55AA55AA);
    check("mtboth lo", 64'(bus.lo), 64'h55AA55AA);

    // MT writes while busy are dropped
    do_mult("mt_busy", 1'b0, 32'd2, 32'd3, 32'h0, 32'h6, 1'b1, 1'b0, 1'b0);
    // MTHI alongside accepted start is dropped
    do_mult("mt_start", 1'b1, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b1);
    // Second start during FIX is ignored: exactly one done over the window
    fork
      do_mult("start_fix", 1'b0, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
      begin
        dones = 0;
        repeat (12) begin
          @(negedge clk);
          if (bus.done) dones++;
        end
      end
    join
    check("start_fix done count", 64'(dones), 64'd1);
    check("start_fix busy after", 64'(bus.busy), 64'd0);

    // Asynchronous reset during FIX aborts without commit
    mt_write(1'b1, 1'b0, 32'hAAAAAAAA);
    check("abort pre hi", 64'(bus.hi), 64'hAAAAAAAA);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.op_a      = 32'd7;
    bus.op_b      = 32'd9;
    bus.product   = 64'd63;
    @(negedge clk);
    idle_inputs();
    check("abort in FIX busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort hi",    64'(bus.hi),    64'd0);
    check("abort lo",    64'(bus.lo),    64'd0);
    check("abort busy",  64'(bus.busy),  64'd0);
    check("abort stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    check("abort hi stays", 64'(bus.hi), 64'd0);
    check("abort lo stays", 64'(bus.lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
